muxnway_rr: RTL and testbench

Parametrised successor to the 8-way 16-bit combinational multiplexer. It merges N valid/ready input channels of WIDTH bits onto one registered output channel, with one cycle of latency. The channel is chosen either by an explicit select (fixed mode) or by a round-robin arbiter (rr mode). It sits between multiple producers and a single consumer wherever a plain mux would lose data under back-pressure.

---
 rtl/muxnway_rr.sv | 94 +++++++++
 tb/tb_muxnway_rr.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/muxnway_rr.sv
// N-way valid/ready merge onto one registered output channel.
// Source is chosen by an explicit select (mode 0) or a round-robin arbiter (mode 1).
module muxnway_rr #(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  ptr_next;
    logic             load;
    logic [N-1:0]     grant;
    logic             gnt_any;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] chan_data [N];

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign chan_data[k] = in_data[k*WIDTH +: WIDTH];
    end

    // Output register accepts a new word when empty or being drained this cycle.
    assign load = !out_valid || out_ready;

    always_comb begin
        int idx;
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (!mode) begin
            for (int k = 0; k < N; k++) begin
                if (sel == SELW'(k) && in_valid[k]) begin
                    grant[k] = 1'b1;
                    gnt_any  = 1'b1;
                    gnt_idx  = SELW'(k);
                end
            end
        end else begin
            // Rotating scan starting at ptr; first valid channel wins.
            for (int i = 0; i < N; i++) begin
                idx = int'(ptr) + i;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!gnt_any && in_valid[idx]) begin
                    grant[idx] = 1'b1;
                    gnt_any    = 1'b1;
                    gnt_idx    = SELW'(idx);
                end
            end
        end
    end

    assign ptr_next = (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + 1'b1;
    assign in_ready = rst_n ? (grant & {N{load}}) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_chan  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            if (gnt_any) begin
                out_data  <= chan_data[gnt_idx];
                out_chan  <= gnt_idx;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Pointer advances only on an actual round-robin transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load && gnt_any && mode) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: tb/tb_muxnway_rr.sv
// Self-checking bench for muxnway_rr: an 8-channel and a 6-channel instance share
// stimulus and are each compared against a behavioural reference model.
module tb_muxnway_rr;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  chan_word [8];
    logic [7:0]   valid_vec;
    logic         mode;
    logic [2:0]   sel;
    logic         out_ready;
    logic [127:0] in_data8;
    logic [95:0]  in_data6;

    logic [7:0]   in_ready8;
    logic [15:0]  out_data8;
    logic [2:0]   out_chan8;
    logic         out_valid8;
    logic [5:0]   in_ready6;
    logic [15:0]  out_data6;
    logic [2:0]   out_chan6;
    logic         out_valid6;

    int checks = 0;
    int errors = 0;

    int          mdl_n     [2] = '{8, 6};
    int          mdl_ptr   [2];
    bit          mdl_valid [2];
    logic [15:0] mdl_data  [2];
    int          mdl_chan  [2];

    always #5 clk = ~clk;

    always_comb begin
        in_data8 = '0;
        for (int k = 0; k < 8; k++) begin
            in_data8[k*16 +: 16] = chan_word[k];
        end
        in_data6 = in_data8[95:0];
    end

    muxnway_rr #(.WIDTH(16), .N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data8), .in_valid(valid_vec),
        .in_ready(in_ready8), .mode(mode), .sel(sel), .out_data(out_data8),
        .out_chan(out_chan8), .out_valid(out_valid8), .out_ready(out_ready)
    );

    muxnway_rr #(.WIDTH(16), .N(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data6), .in_valid(valid_vec[5:0]),
        .in_ready(in_ready6), .mode(mode), .sel(sel), .out_data(out_data6),
        .out_chan(out_chan6), .out_valid(out_valid6), .out_ready(out_ready)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference arbitration: fixed select or a modular scan from the pointer.
    function automatic int pick(int n, int p, logic md, logic [2:0] s, logic [7:0] v);
        if (!md) begin
            if (int'(s) < n && v[s]) return int'(s);
            return -1;
        end
        for (int i = 0; i < n; i++) begin
            if (v[(p + i) % n]) return (p + i) % n;
        end
        return -1;
    endfunction

    task automatic resetModel();
        for (int m = 0; m < 2; m++) begin
            mdl_ptr[m]   = 0;
            mdl_valid[m] = 1'b0;
            mdl_data[m]  = 16'h0;
            mdl_chan[m]  = 0;
        end
    endtask

    task automatic checkRegs();
        checkOutput("out_valid8", 32'(out_valid8), 32'(mdl_valid[0]));
        checkOutput("out_data8",  32'(out_data8),  32'(mdl_data[0]));
        checkOutput("out_chan8",  32'(out_chan8),  32'(mdl_chan[0]));
        checkOutput("out_valid6", 32'(out_valid6), 32'(mdl_valid[1]));
        checkOutput("out_data6",  32'(out_data6),  32'(mdl_data[1]));
        checkOutput("out_chan6",  32'(out_chan6),  32'(mdl_chan[1]));
    endtask

    // One clock: check combinational ready, advance model at the edge, check registers.
    task automatic stepCycle();
        int          w  [2];
        bit          ld [2];
        logic [31:0] exp_rdy [2];
        #1;
        for (int m = 0; m < 2; m++) begin
            w[m]  = pick(mdl_n[m], mdl_ptr[m], mode, sel, valid_vec);
            ld[m] = !mdl_valid[m] || out_ready;
            exp_rdy[m] = (rst_n && ld[m] && w[m] >= 0) ? (32'd1 << w[m]) : 32'd0;
        end
        checkOutput("in_ready8", 32'(in_ready8), exp_rdy[0]);
        checkOutput("in_ready6", 32'(in_ready6), exp_rdy[1]);
        @(posedge clk);
        if (!rst_n) begin
            resetModel();
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (ld[m]) begin
                    if (w[m] >= 0) begin
                        mdl_data[m]  = chan_word[w[m]];
                        mdl_chan[m]  = w[m];
                        mdl_valid[m] = 1'b1;
                        if (mode) mdl_ptr[m] = (w[m] + 1) % mdl_n[m];
                    end else begin
                        mdl_valid[m] = 1'b0;
                    end
                end
            end
        end
        #1;
        checkRegs();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic md, input logic [2:0] s, input logic [7:0] v, input logic ordy);
        mode      = md;
        sel       = s;
        valid_vec = v;
        out_ready = ordy;
        stepCycle();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] init_words [8];
        init_words = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD,
                       16'h0001, 16'h0010, 16'h0100, 16'h1000};
        for (int k = 0; k < 8; k++) chan_word[k] = init_words[k];
        resetModel();
        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = 3'd0;
        valid_vec = 8'hFF;
        out_ready = 1'b1;
        @(negedge clk);

        $display("[TB] reset with all channels valid");
        applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1);
        applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1);
        rst_n = 1'b1;

        $display("[TB] fixed-mode select sweep");
        for (int s = 0; s < 8; s++) applyStimulus(1'b0, 3'(s), 8'hFF, 1'b1);

        $display("[TB] round-robin fairness");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1);
            checkOutput("rr_order8", 32'(out_chan8), 32'(i % 8));
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 3'd0, 8'b0010_0100, 1'b1);

        $display("[TB] back-pressure");
        applyStimulus(1'b1, 3'd0, 8'b0000_0100, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'd0, 8'hFF, 1'b0);
        applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1);
        checkOutput("bp_release8", 32'(out_data8), 32'h0000DDDD);

        $display("[TB] bubble and pointer wrap");
        applyStimulus(1'b1, 3'd0, 8'h00, 1'b1);
        applyStimulus(1'b1, 3'd0, 8'h80, 1'b1);
        applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1);

        $display("[TB] invalid select and mode switch");
        applyStimulus(1'b0, 3'd7, 8'hFF, 1'b1);
        applyStimulus(1'b1, 3'd0, 8'b0000_1000, 1'b1);
        applyStimulus(1'b1, 3'd0, 8'b0001_0010, 1'b1);
        applyStimulus(1'b1, 3'd0, 8'b0001_0010, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) chan_word[$urandom_range(0, 7)] = 16'($urandom);
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          8'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("[TB] asynchronous reset mid-stream");
        mode = 1'b1; valid_vec = 8'hFF; out_ready = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        resetModel();
        checkRegs();
        checkOutput("in_ready8_rst", 32'(in_ready8), 32'd0);
        checkOutput("in_ready6_rst", 32'(in_ready6), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1);
        checkOutput("first_rr_after_reset", 32'(out_chan8), 32'd0);
        applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
